// File: rtl/trng_entropy_collector_if.sv
// Conditioner-side read bus of the entropy collector: block handshake and word read port.
interface trng_entropy_collector_if #(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_ADDR_WIDTH = 4
);
    logic                    Entropy_Consume;
    logic [P_ADDR_WIDTH-1:0] Rd_Addr;
    logic [P_DATA_WIDTH-1:0] Rd_Data;
    logic                    Entropy_Ready;

    // Conditioner side
    modport master (
        output Entropy_Consume,
        output Rd_Addr,
        input  Rd_Data,
        input  Entropy_Ready
    );

    // Collector side
    modport slave (
        input  Entropy_Consume,
        input  Rd_Addr,
        output Rd_Data,
        output Entropy_Ready
    );
endinterface

// File: rtl/trng_entropy_collector.sv
// Raw noise sampler with RCT/APT health tests, packing healthy bits into one hash block.
module trng_entropy_collector #(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_WORDS      = 16,
    parameter int unsigned P_ADDR_WIDTH = 4,
    parameter int unsigned P_RCT_CUTOFF = 32,
    parameter int unsigned P_APT_WINDOW = 512,
    parameter int unsigned P_APT_CUTOFF = 410
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           Collect_Go,
    input  logic                           raw_bit,
    input  logic                           raw_valid,
    input  logic                           Clear_Fail,
    trng_entropy_collector_if.slave        rd_bus,
    output logic                           Health_Fail,
    output logic [7:0]                     Fail_Count
);
    localparam int unsigned BIT_W     = $clog2(P_DATA_WIDTH);
    localparam int unsigned RCT_W     = $clog2(P_RCT_CUTOFF + 1);
    localparam int unsigned APT_POS_W = $clog2(P_APT_WINDOW);
    localparam int unsigned APT_CNT_W = $clog2(P_APT_WINDOW + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL, FAIL} state_t;

    state_t                  state, state_nxt;
    logic [P_ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic [P_DATA_WIDTH-1:0] word, word_nxt;
    logic [RCT_W-1:0]        rct_run, rct_run_nxt;
    logic                    prev_bit, prev_bit_nxt;
    logic [APT_POS_W-1:0]    apt_pos, apt_pos_nxt;
    logic [APT_CNT_W-1:0]    apt_cnt, apt_cnt_nxt;
    logic                    apt_ref, apt_ref_nxt;
    logic [7:0]              fail_count_nxt;
    logic                    mem_we;
    logic [P_DATA_WIDTH-1:0] rd_data_q;
    logic                    ready_q;

    logic [P_DATA_WIDTH-1:0] mem [P_WORDS];

    // Next-state, health tests and word packing
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        bit_cnt_nxt    = bit_cnt;
        word_nxt       = word;
        rct_run_nxt    = rct_run;
        prev_bit_nxt   = prev_bit;
        apt_pos_nxt    = apt_pos;
        apt_cnt_nxt    = apt_cnt;
        apt_ref_nxt    = apt_ref;
        fail_count_nxt = Fail_Count;
        mem_we         = 1'b0;

        case (state)
            IDLE: begin
                if (Collect_Go) begin
                    state_nxt   = COLLECT;
                    ptr_nxt     = '0;
                    bit_cnt_nxt = '0;
                    rct_run_nxt = '0;
                    apt_pos_nxt = '0;
                    apt_cnt_nxt = '0;
                end
            end
            COLLECT: begin
                if (raw_valid) begin
                    word_nxt[bit_cnt] = raw_bit;
                    prev_bit_nxt      = raw_bit;
                    // A zero run length marks the first bit after Go
                    if (rct_run == '0 || raw_bit != prev_bit)
                        rct_run_nxt = RCT_W'(1);
                    else
                        rct_run_nxt = RCT_W'(rct_run + RCT_W'(1));
                    // Window position zero captures the reference bit
                    if (apt_pos == '0) begin
                        apt_ref_nxt = raw_bit;
                        apt_cnt_nxt = APT_CNT_W'(1);
                    end else if (raw_bit == apt_ref) begin
                        apt_cnt_nxt = APT_CNT_W'(apt_cnt + APT_CNT_W'(1));
                    end
                    apt_pos_nxt = (apt_pos == APT_POS_W'(P_APT_WINDOW - 1)) ? '0
                                : APT_POS_W'(apt_pos + APT_POS_W'(1));

                    if (rct_run_nxt == RCT_W'(P_RCT_CUTOFF) ||
                        apt_cnt_nxt == APT_CNT_W'(P_APT_CUTOFF)) begin
                        state_nxt      = FAIL;
                        ptr_nxt        = '0;
                        bit_cnt_nxt    = '0;
                        fail_count_nxt = (Fail_Count == 8'hFF) ? Fail_Count
                                       : 8'(Fail_Count + 8'd1);
                    end else if (bit_cnt == BIT_W'(P_DATA_WIDTH - 1)) begin
                        mem_we      = 1'b1;
                        bit_cnt_nxt = '0;
                        if (ptr == P_ADDR_WIDTH'(P_WORDS - 1)) begin
                            ptr_nxt   = '0;
                            state_nxt = FULL;
                        end else begin
                            ptr_nxt = P_ADDR_WIDTH'(ptr + P_ADDR_WIDTH'(1));
                        end
                    end else begin
                        bit_cnt_nxt = BIT_W'(bit_cnt + BIT_W'(1));
                    end
                end
            end
            FULL: begin
                if (rd_bus.Entropy_Consume) begin
                    state_nxt   = COLLECT;
                    ptr_nxt     = '0;
                    bit_cnt_nxt = '0;
                end
            end
            FAIL: begin
                if (Clear_Fail)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            bit_cnt     <= '0;
            word        <= '0;
            rct_run     <= '0;
            prev_bit    <= 1'b0;
            apt_pos     <= '0;
            apt_cnt     <= '0;
            apt_ref     <= 1'b0;
            Fail_Count  <= '0;
            Health_Fail <= 1'b0;
            ready_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            word        <= word_nxt;
            rct_run     <= rct_run_nxt;
            prev_bit    <= prev_bit_nxt;
            apt_pos     <= apt_pos_nxt;
            apt_cnt     <= apt_cnt_nxt;
            apt_ref     <= apt_ref_nxt;
            Fail_Count  <= fail_count_nxt;
            Health_Fail <= (state_nxt == FAIL);
            ready_q     <= (state_nxt == FULL);
            rd_data_q   <= mem[rd_bus.Rd_Addr];
        end
    end

    // Block buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (mem_we && !Reset)
            mem[ptr] <= word_nxt;
    end

    assign rd_bus.Rd_Data       = rd_data_q;
    assign rd_bus.Entropy_Ready = ready_q;
endmodule

// File: tb/tb_trng_entropy_collector.sv
// Directed bench for trng_entropy_collector: fill, refill, health failures and reset abort.
module tb_trng_entropy_collector;
    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Collect_Go = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       Clear_Fail = 1'b0;
    logic       Health_Fail;
    logic [7:0] Fail_Count;

    int n_checks = 0;
    int n_fail   = 0;

    trng_entropy_collector_if #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(4)) rd_bus ();

    trng_entropy_collector dut (
        .clk         (clk),
        .Reset       (Reset),
        .Collect_Go  (Collect_Go),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .Clear_Fail  (Clear_Fail),
        .rd_bus      (rd_bus.slave),
        .Health_Fail (Health_Fail),
        .Fail_Count  (Fail_Count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0: 1,0,1,0..  1: all ones  2: 31 ones then a zero  3: 1,0,0,0 repeating
    function automatic logic bit_of(input int kind, input int i);
        case (kind)
            0:       return (i % 2 == 0);
            1:       return 1'b1;
            2:       return (i % 32 != 31);
            default: return (i % 4 == 0);
        endcase
    endfunction

    task automatic send_bits(input int n, input int kind, input int duty, input int start);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < duty - 1; d++) begin
                @(negedge clk);
                raw_valid = 1'b0;
                raw_bit   = ~raw_bit;
            end
            @(negedge clk);
            raw_bit   = bit_of(kind, start + i);
            raw_valid = 1'b1;
        end
        @(negedge clk);
        raw_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk);
        Collect_Go = 1'b1;
        @(negedge clk);
        Collect_Go = 1'b0;
    endtask

    task automatic read_check(input int a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        rd_bus.Rd_Addr = 4'(a);
        @(negedge clk);
        check_eq(tag, rd_bus.Rd_Data, exp);
    endtask

    initial begin
        rd_bus.Rd_Addr         = '0;
        rd_bus.Entropy_Consume = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_rd_data", rd_bus.Rd_Data, 32'h0);
        check_eq("rst_ready", 32'(rd_bus.Entropy_Ready), 32'h0);
        check_eq("rst_health_fail", 32'(Health_Fail), 32'h0);
        check_eq("rst_fail_count", 32'(Fail_Count), 32'h0);
        Reset = 1'b0;

        // T1: full block of alternating bits
        pulse_go();
        send_bits(511, 0, 1, 0);
        check_eq("t1_ready_before_last", 32'(rd_bus.Entropy_Ready), 32'h0);
        send_bits(1, 0, 1, 511);
        check_eq("t1_ready", 32'(rd_bus.Entropy_Ready), 32'h1);
        check_eq("t1_health_fail", 32'(Health_Fail), 32'h0);
        check_eq("t1_fail_count", 32'(Fail_Count), 32'h0);
        for (int w = 0; w < 16; w++)
            read_check(w, 32'h5555_5555, $sformatf("t1_word%0d", w));

        // T5: consume with raw_valid held high, refill with 1,0,0,0 pattern
        @(negedge clk);
        check_eq("t5_ready_before_consume", 32'(rd_bus.Entropy_Ready), 32'h1);
        rd_bus.Entropy_Consume = 1'b1;
        raw_valid = 1'b1;
        raw_bit   = 1'b1;
        @(negedge clk);
        rd_bus.Entropy_Consume = 1'b0;
        check_eq("t5_ready_after_consume", 32'(rd_bus.Entropy_Ready), 32'h0);
        raw_bit = bit_of(3, 0);
        for (int i = 1; i < 512; i++) begin
            @(negedge clk);
            if (i == 511)
                check_eq("t5_ready_before_last", 32'(rd_bus.Entropy_Ready), 32'h0);
            raw_bit = bit_of(3, i);
        end
        @(negedge clk);
        raw_valid = 1'b0;
        check_eq("t5_ready_refilled", 32'(rd_bus.Entropy_Ready), 32'h1);
        check_eq("t5_health_fail", 32'(Health_Fail), 32'h0);
        read_check(0, 32'h1111_1111, "t5_word0");
        read_check(5, 32'h1111_1111, "t5_word5");
        read_check(15, 32'h1111_1111, "t5_word15");

        // T2: alternating bits, valid one cycle in three
        do_reset();
        check_eq("t2_ready_after_reset", 32'(rd_bus.Entropy_Ready), 32'h0);
        pulse_go();
        send_bits(511, 0, 3, 0);
        check_eq("t2_ready_before_last", 32'(rd_bus.Entropy_Ready), 32'h0);
        send_bits(1, 0, 3, 511);
        check_eq("t2_ready", 32'(rd_bus.Entropy_Ready), 32'h1);
        check_eq("t2_health_fail", 32'(Health_Fail), 32'h0);
        read_check(0, 32'h5555_5555, "t2_word0");
        read_check(9, 32'h5555_5555, "t2_word9");
        read_check(15, 32'h5555_5555, "t2_word15");

        // T3: 32 identical ones trip RCT
        do_reset();
        pulse_go();
        send_bits(31, 1, 1, 0);
        check_eq("t3_hf_before", 32'(Health_Fail), 32'h0);
        send_bits(1, 1, 1, 31);
        check_eq("t3_health_fail", 32'(Health_Fail), 32'h1);
        check_eq("t3_fail_count", 32'(Fail_Count), 32'h1);
        check_eq("t3_ready", 32'(rd_bus.Entropy_Ready), 32'h0);
        @(negedge clk);
        Clear_Fail = 1'b1;
        @(negedge clk);
        Clear_Fail = 1'b0;
        check_eq("t3_hf_cleared", 32'(Health_Fail), 32'h0);
        check_eq("t3_fail_count_kept", 32'(Fail_Count), 32'h1);

        // T4: 31 ones then a zero; APT trips on bit 423
        do_reset();
        pulse_go();
        send_bits(422, 2, 1, 0);
        check_eq("t4_hf_before", 32'(Health_Fail), 32'h0);
        send_bits(1, 2, 1, 422);
        check_eq("t4_health_fail", 32'(Health_Fail), 32'h1);
        check_eq("t4_fail_count", 32'(Fail_Count), 32'h1);
        check_eq("t4_ready", 32'(rd_bus.Entropy_Ready), 32'h0);

        // T6: reset at bit 200 aborts; later bits without Go are ignored
        do_reset();
        pulse_go();
        send_bits(199, 0, 1, 0);
        @(negedge clk);
        raw_bit   = bit_of(0, 199);
        raw_valid = 1'b1;
        Reset     = 1'b1;
        @(negedge clk);
        Reset     = 1'b0;
        raw_valid = 1'b0;
        check_eq("t6_rd_data", rd_bus.Rd_Data, 32'h0);
        check_eq("t6_ready", 32'(rd_bus.Entropy_Ready), 32'h0);
        check_eq("t6_health_fail", 32'(Health_Fail), 32'h0);
        check_eq("t6_fail_count", 32'(Fail_Count), 32'h0);
        send_bits(600, 1, 1, 0);
        check_eq("t6_ready_no_go", 32'(rd_bus.Entropy_Ready), 32'h0);
        check_eq("t6_hf_no_go", 32'(Health_Fail), 32'h0);
        check_eq("t6_fc_no_go", 32'(Fail_Count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
